// File: rtl/attopu_ctrl.sv
// Fetch/decode/execute sequencer for the attopu core: fetches over imem req/ack,
// drives register-file ports and ALU controls, and resolves branches from ALU flags.
module attopu_ctrl #(
  parameter int unsigned     PC_W     = 12,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            halted,
  output logic            busy,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [3:0]      rf_raddr1,
  output logic [3:0]      rf_raddr2,
  input  logic [15:0]     rf_rdata1,
  input  logic [15:0]     rf_rdata2,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [15:0]     rf_wdata,
  output logic [6:0]      alu_op,
  output logic [15:0]     alu_in1,
  output logic [15:0]     alu_in2,
  input  logic [15:0]     alu_out,
  input  logic            c_flag,
  input  logic            z_flag
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALTED} state_t;

  localparam logic [3:0] OP_MV   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_JZ   = 4'h4;
  localparam logic [3:0] OP_JC   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic [3:0]  op;
  logic        taken;

  always_comb begin
    op    = ir[15:12];
    taken = (op == OP_JMP) || ((op == OP_JZ) && z_flag) || ((op == OP_JC) && c_flag);
  end

  assign imem_addr = pc;
  assign rf_raddr1 = ir[11:8];
  assign rf_raddr2 = ir[7:4];
  assign rf_waddr  = ir[11:8];
  assign rf_wdata  = alu_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= START_PC;
      ir <= '0;
    end else begin
      if (((state == IDLE) || (state == HALTED)) && start)
        pc <= START_PC;
      else if ((state == EXEC) && (op != OP_HALT))
        pc <= taken ? ir[PC_W-1:0] : pc + PC_W'(1);
      if ((state == FETCH) && imem_ack)
        ir <= imem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, HALTED: if (start) state_nxt = FETCH;
      FETCH:        if (imem_ack) state_nxt = DECODE;
      DECODE:       state_nxt = EXEC;
      EXEC:         state_nxt = (op == OP_HALT) ? HALTED : FETCH;
      default:      state_nxt = IDLE;
    endcase
  end

  // alu_op stays 0 outside an ADD's EXEC so the ALU flags hold between ADDs.
  always_comb begin
    imem_req = 1'b0;
    rf_we    = 1'b0;
    alu_op   = '0;
    alu_in1  = '0;
    alu_in2  = '0;
    busy     = 1'b0;
    halted   = 1'b0;
    unique case (state)
      FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
      end
      DECODE: busy = 1'b1;
      EXEC: begin
        busy = 1'b1;
        case (op)
          OP_MV: begin
            alu_in1 = rf_rdata2;
            rf_we   = 1'b1;
          end
          OP_ADD: begin
            alu_op  = 7'd1;
            alu_in1 = rf_rdata1;
            alu_in2 = rf_rdata2;
            rf_we   = 1'b1;
          end
          OP_LDI: begin
            alu_in1 = {8'h00, ir[7:0]};
            rf_we   = 1'b1;
          end
          default: ;
        endcase
      end
      HALTED:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_attopu_ctrl.sv
// Bench for attopu_ctrl: instruction-level model with fixed phase latencies checked
// every cycle, plus directed programs with hand-computed architectural results.
module tb_attopu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halted, busy;
  logic [11:0] pc, imem_addr;
  logic        imem_req, imem_ack;
  logic [15:0] imem_rdata;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;
  logic [6:0]  alu_op;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic        c_flag, z_flag;

  logic        start_w = 1'b0;
  logic        halted_w, busy_w, imem_req_w, imem_ack_w, rf_we_w;
  logic [3:0]  pc_w, imem_addr_w, rf_raddr1_w, rf_raddr2_w, rf_waddr_w;
  logic [15:0] imem_rdata_w, rf_wdata_w, alu_in1_w, alu_in2_w;
  logic [6:0]  alu_op_w;

  always #5 clk = ~clk;

  attopu_ctrl #(.PC_W(12), .START_PC(12'd0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .halted(halted), .busy(busy), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_op(alu_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .c_flag(c_flag), .z_flag(z_flag)
  );

  attopu_ctrl #(.PC_W(4), .START_PC(4'd14)) u_wrap (
    .clk(clk), .rst(rst), .start(start_w), .halted(halted_w), .busy(busy_w), .pc(pc_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w), .imem_ack(imem_ack_w),
    .rf_raddr1(rf_raddr1_w), .rf_raddr2(rf_raddr2_w), .rf_rdata1(16'h0000), .rf_rdata2(16'h0000),
    .rf_we(rf_we_w), .rf_waddr(rf_waddr_w), .rf_wdata(rf_wdata_w), .alu_op(alu_op_w),
    .alu_in1(alu_in1_w), .alu_in2(alu_in2_w), .alu_out(16'h0000), .c_flag(1'b0), .z_flag(1'b0)
  );

  // Environment: instruction memory with programmable ack delay, register file, ALU.
  logic [15:0] mem [4096];
  logic [15:0] regs [16] = '{default: 16'h0000};
  int unsigned ack_delay = 0;
  int unsigned wait_cnt = 0;
  logic        force_ack = 1'b0;
  logic        zf, cf;
  logic [16:0] alu_sum;
  int          add_cnt = 0;
  int          we_cnt = 0;

  assign imem_ack   = (imem_req && (wait_cnt == ack_delay)) || force_ack;
  assign imem_rdata = mem[imem_addr];
  assign rf_rdata1  = regs[rf_raddr1];
  assign rf_rdata2  = regs[rf_raddr2];
  assign alu_sum    = {1'b0, alu_in1} + {1'b0, alu_in2};
  assign alu_out    = (alu_op == 7'd1) ? alu_sum[15:0] : alu_in1;
  assign c_flag     = cf;
  assign z_flag     = zf;

  assign imem_ack_w   = imem_req_w;
  assign imem_rdata_w = (imem_addr_w == 4'd0) ? 16'hF000 : 16'h6000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cf <= 1'b0;
      zf <= 1'b0;
      wait_cnt <= 0;
    end else begin
      if (alu_op == 7'd1) begin
        cf <= alu_sum[16];
        zf <= (alu_sum[15:0] == 16'h0000);
      end
      if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else                       wait_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    if (alu_op == 7'd1) add_cnt <= add_cnt + 1;
    if (rf_we) we_cnt <= we_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-level model: fetch lasts until ack, then one decode and one execute cycle.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_HALTED = 4;
  int          m_phase = PH_IDLE;
  logic [11:0] m_pc = '0;
  logic [15:0] m_ir = '0;
  logic        m_z = 1'b0, m_c = 1'b0;
  logic [15:0] m_regs [16] = '{default: 16'h0000};

  always @(negedge clk) begin
    logic [15:0] e_in1, e_in2, e_wdata;
    logic        e_we, taken;
    logic [6:0]  e_op;
    logic [3:0]  op, rd, rs;
    logic [16:0] s;
    if (rst) begin
      m_phase = PH_IDLE;
      m_pc = '0;
      m_ir = '0;
      m_z = 1'b0;
      m_c = 1'b0;
    end
    op = m_ir[15:12];
    rd = m_ir[11:8];
    rs = m_ir[7:4];
    e_in1 = '0; e_in2 = '0; e_wdata = '0; e_we = 1'b0; e_op = '0; s = '0;
    if (m_phase == PH_EXEC) begin
      case (op)
        4'h0: begin e_in1 = m_regs[rs]; e_we = 1'b1; e_wdata = e_in1; end
        4'h1: begin
          e_op = 7'd1; e_in1 = m_regs[rd]; e_in2 = m_regs[rs];
          s = {1'b0, e_in1} + {1'b0, e_in2};
          e_we = 1'b1; e_wdata = s[15:0];
        end
        4'h2: begin e_in1 = {8'h00, m_ir[7:0]}; e_we = 1'b1; e_wdata = e_in1; end
        default: ;
      endcase
    end
    chk("busy", 32'(busy), 32'((m_phase == PH_FETCH) || (m_phase == PH_DECODE) || (m_phase == PH_EXEC)));
    chk("halted", 32'(halted), 32'(m_phase == PH_HALTED));
    chk("imem_req", 32'(imem_req), 32'(m_phase == PH_FETCH));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("rf_raddr1", 32'(rf_raddr1), 32'(rd));
    chk("rf_raddr2", 32'(rf_raddr2), 32'(rs));
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("alu_op", 32'(alu_op), 32'(e_op));
    chk("alu_in1", 32'(alu_in1), 32'(e_in1));
    chk("alu_in2", 32'(alu_in2), 32'(e_in2));
    if (e_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(rd));
      chk("rf_wdata", 32'(rf_wdata), 32'(e_wdata));
    end
    chk("wrap_quiet", 32'({rf_raddr1_w, rf_raddr2_w, rf_waddr_w, rf_we_w, alu_op_w}), 32'd0);
    chk("wrap_data_quiet", {alu_in1_w, alu_in2_w} | 32'(rf_wdata_w), 32'd0);
    chk("wrap_addr", 32'(imem_addr_w), 32'(pc_w));
    if (!rst) begin
      case (m_phase)
        PH_IDLE, PH_HALTED: if (start) begin m_phase = PH_FETCH; m_pc = 12'd0; end
        PH_FETCH: if (imem_ack) begin m_ir = mem[m_pc]; m_phase = PH_DECODE; end
        PH_DECODE: m_phase = PH_EXEC;
        PH_EXEC: begin
          taken = (op == 4'h3) || ((op == 4'h4) && m_z) || ((op == 4'h5) && m_c);
          if (e_we) m_regs[rd] = e_wdata;
          if (op == 4'h1) begin m_c = s[16]; m_z = (s[15:0] == 16'h0000); end
          if (op == 4'hF) m_phase = PH_HALTED;
          else begin
            m_phase = PH_FETCH;
            m_pc = taken ? m_ir[11:0] : m_pc + 12'd1;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'hE000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run_to_halt(output int n);
    n = 0;
    while (!halted && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    int n, w0, a0;
    clear_mem();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    // LDI r1,FF; LDI r2,01; ADD r1,r2; HALT with zero-wait acks.
    mem[0] = 16'h21FF; mem[1] = 16'h2201; mem[2] = 16'h1120; mem[3] = 16'hF000;
    pulse_start();
    run_to_halt(n);
    chk("t1_cycles", 32'(n), 32'd12);
    chk("t1_pc", 32'(pc), 32'd3);
    chk("t1_r1", 32'(regs[1]), 32'h0100);
    chk("t1_flags", 32'({zf, cf}), 32'd0);

    // Build 0xFFFF in r1, add 1 -> 0 with carry; JZ taken to 0x010.
    clear_mem();
    mem[0] = 16'h21FF;
    for (int i = 1; i <= 8; i++) mem[i] = 16'h1110;
    mem[9] = 16'h23FF; mem[10] = 16'h1130; mem[11] = 16'h2201; mem[12] = 16'h1120;
    mem[13] = 16'h4010; mem[14] = 16'hF000; mem[16] = 16'hF000;
    pulse_start();
    run_to_halt(n);
    chk("t2a_pc", 32'(pc), 32'h010);
    chk("t2a_r1", 32'(regs[1]), 32'h0000);
    chk("t2a_zc", 32'({zf, cf}), 32'b11);

    // Same with r2 = 2: JZ falls through, JC at 14 taken to 0x010.
    mem[11] = 16'h2202; mem[14] = 16'h5010; mem[15] = 16'hF000;
    pulse_start();
    run_to_halt(n);
    chk("t2b_pc", 32'(pc), 32'h010);
    chk("t2b_r1", 32'(regs[1]), 32'h0001);
    chk("t2b_zc", 32'({zf, cf}), 32'b01);

    // Flags hold across MV and LDI.
    clear_mem();
    mem[0] = 16'h2100; mem[1] = 16'h2200; mem[2] = 16'h1120; mem[3] = 16'h0310;
    mem[4] = 16'h2400; mem[5] = 16'h4020; mem[6] = 16'hF000; mem[32] = 16'hF000;
    a0 = add_cnt;
    pulse_start();
    run_to_halt(n);
    chk("t3_pc", 32'(pc), 32'h020);
    chk("t3_r3", 32'(regs[3]), 32'h0000);
    chk("t3_add_cycles", 32'(add_cnt - a0), 32'd1);

    // Five wait cycles per fetch.
    clear_mem();
    mem[0] = 16'h2512; mem[1] = 16'hF000;
    ack_delay = 5;
    pulse_start();
    run_to_halt(n);
    chk("t4_cycles", 32'(n), 32'd16);
    chk("t4_r5", 32'(regs[5]), 32'h0012);

    // Reset during a pending fetch, then a stray ack while idle.
    clear_mem();
    mem[0] = 16'h2677; mem[1] = 16'hF000;
    w0 = we_cnt;
    pulse_start();
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_req", 32'(imem_req), 32'd0);
    chk("t5_pc", 32'(pc), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2 force_ack = 1'b0;
    chk("t5_late_ack_busy", 32'(busy), 32'd0);
    chk("t5_r6", 32'(regs[6]), 32'h0000);
    chk("t5_no_we", 32'(we_cnt - w0), 32'd0);

    // Reset during EXEC of ADD r7,r7.
    clear_mem();
    mem[0] = 16'h2703; mem[1] = 16'h1770; mem[2] = 16'hF000;
    ack_delay = 0;
    w0 = we_cnt;
    pulse_start();
    repeat (5) begin @(posedge clk); #2; end
    chk("t6_in_add", 32'(alu_op), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_we", 32'(rf_we), 32'd0);
    chk("t6_op", 32'(alu_op), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;
    chk("t6_r7", 32'(regs[7]), 32'h0003);
    chk("t6_we_count", 32'(we_cnt - w0), 32'd1);
    chk("t6_pc", 32'(pc), 32'd0);

    // 4-bit PC: NOPs at 14 and 15 wrap to a HALT at 0; restart resumes at 14.
    start_w = 1'b1;
    @(posedge clk); #2 start_w = 1'b0;
    chk("w_start_pc", 32'(pc_w), 32'd14);
    repeat (3) @(posedge clk);
    #2 chk("w_pc15", 32'(pc_w), 32'd15);
    repeat (3) @(posedge clk);
    #2 chk("w_pc_wrap", 32'(pc_w), 32'd0);
    repeat (3) @(posedge clk);
    #2 chk("w_halted", 32'(halted_w), 32'd1);
    chk("w_halt_pc", 32'(pc_w), 32'd0);
    start_w = 1'b1;
    @(posedge clk); #2 start_w = 1'b0;
    chk("w_restart_busy", 32'(busy_w), 32'd1);
    chk("w_restart_pc", 32'(pc_w), 32'd14);

    @(posedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/attopu_ctrl.md
Name: attopu_ctrl

Overview:
- Multi-cycle fetch/decode/execute sequencer for the attopu core.
- Fetches 16-bit instructions over a req/ack instruction-memory port and drives the external register file read and write ports.
- Drives the ALU op and operand muxes, and resolves conditional branches from the ALU's registered carry and zero flags.
- Sits between the instruction memory, the 16x16 register file and the ALU; it is the only block that sequences the ALU.

Parameters:
- PC_W, 12, program counter width; legal range 1..12. Branch targets are taken from instr[PC_W-1:0].
- START_PC, 0, PC value loaded on every start.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin execution; honoured only in IDLE or HALTED
- halted  out  1  high while in HALTED
- busy  out  1  high in FETCH, DECODE and EXEC
- pc  out  PC_W  current program counter
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address; equals pc
- imem_rdata  in  16  fetched instruction
- imem_ack  in  1  fetch complete; imem_rdata is valid this cycle
- rf_raddr1  out  4  read address 1 = ir[11:8] (rd)
- rf_raddr2  out  4  read address 2 = ir[7:4] (rs)
- rf_rdata1  in  16  combinational read data 1
- rf_rdata2  in  16  combinational read data 2
- rf_we  out  1  register write enable
- rf_waddr  out  4  write address = ir[11:8]
- rf_wdata  out  16  write data = alu_out
- alu_op  out  7  ALU opcode; 0 = MV, 1 = ADD
- alu_in1  out  16  ALU operand 1
- alu_in2  out  16  ALU operand 2
- alu_out  in  16  ALU result
- c_flag  in  1  ALU registered carry flag
- z_flag  in  1  ALU registered zero flag

Behaviour:
- Instruction encoding: op = instr[15:12], rd = [11:8], rs = [7:4], imm8 = [7:0], target = [PC_W-1:0].
- Opcodes:
  - 0 MV: rd <= rs.
  - 1 ADD: rd <= rd + rs; flags update.
  - 2 LDI: rd <= {8'h00, imm8}.
  - 3 JMP: pc <= target.
  - 4 JZ: jump if z_flag.
  - 5 JC: jump if c_flag.
  - F HALT.
  - 6..E: NOP (pc increments only).
- Internal 16-bit ir, cleared to 0 on reset.
- State machine:
  - IDLE: start -> FETCH; pc <= START_PC.
  - FETCH: imem_req = 1 and is held until imem_ack. On ack: ir <= imem_rdata, -> DECODE. Ack may arrive in the first FETCH cycle; any number of wait cycles is allowed.
  - DECODE: one cycle. Register file addresses settle from ir.
  - EXEC: one cycle, then -> FETCH, or -> HALTED for HALT.
  - HALTED: start -> FETCH with pc <= START_PC; otherwise stays put.
- Minimum instruction latency: 3 cycles (FETCH 1, DECODE 1, EXEC 1).
- EXEC per opcode:
  - MV: alu_op = 0, alu_in1 = rf_rdata2, rf_we = 1.
  - ADD: alu_op = 1, alu_in1 = rf_rdata1, alu_in2 = rf_rdata2, rf_we = 1. The ALU updates its flags at the end of this cycle.
  - LDI: alu_op = 0, alu_in1 = {8'h00, imm8}, rf_we = 1.
  - Branches: flags are sampled in EXEC and reflect the most recent completed ADD.
- alu_op = 1 only in EXEC of an ADD. alu_op = 0 in every other cycle, so flags hold.
- rf_we = 1 only in EXEC of MV, ADD or LDI.
- alu_in1 and alu_in2 = 0 when not in use.
- PC update in EXEC:
  - Taken branch: pc <= target.
  - All other instructions, and untaken branches: pc <= pc + 1, wrapping modulo 2^PC_W (all-ones -> 0).
  - HALT: pc is left unchanged and points at the HALT instruction.
- start while busy is ignored. imem_ack outside FETCH is ignored.
- Reset values: state IDLE, pc = START_PC, ir = 0. imem_req, rf_we, alu_op, alu_in1, alu_in2, halted and busy are all 0.
- Reset asserted mid-fetch or mid-exec aborts immediately: no register write and no pc change. A pending fetch is dropped, and a late ack is ignored.

Test Plan:
- Fetch timing: start; program LDI r1,0xFF; LDI r2,0x01; ADD r1,r2; HALT. Ack is returned in the same cycle as req. -> r1 = 0x0100, z = 0, c = 0. HALT is reached 12 cycles after FETCH entry. halted = 1 with pc = 3.
- Carry and branch: r1 = 0xFFFF, r2 = 0x0001, ADD r1,r2; JZ 0x010 at the next address. -> r1 = 0x0000, z = 1, c = 1; pc = 0x010 after the JZ. Repeat with r2 = 0x0002: -> z = 0, c = 1; JZ falls through (pc + 1) and JC to the same target is taken.
- Flag hold: ADD producing z = 1, then MV r3,r1 and LDI r4,0 between the ADD and a JZ. -> JZ is still taken. alu_op equals 1 only in the ADD's EXEC cycle.
- Wait states: imem_ack delayed 5 cycles. -> imem_req is held high with a stable imem_addr for all 5 cycles; ir is loaded only on the ack cycle.
- Reset mid-operation: assert rst during FETCH with ack pending, and again during EXEC of an ADD. -> State is IDLE and pc = START_PC; no rf_we pulse occurs; an ack arriving after reset has no effect.
- PC wrap and restart: PC_W = 4, NOPs at addresses 14 and 15. -> pc goes 15 -> 0. A HALT at address 0 then start -> execution resumes at START_PC.
